// File: rtl/rx_operand_loader_pkg.sv
// ============================================================================
// Module : rx_operand_loader_pkg
// Brief  : Shared state encodings, frame constants and byte-placement helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_operand_loader_pkg;

  localparam int OPERAND_W         = 256;
  localparam int BYTES_PER_OPERAND = 32;
  localparam int BYTES_PER_FRAME   = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Bit offset of a byte within its operand (little-endian byte order).
  function automatic logic [7:0] byte_lsb(input logic [4:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_operand_loader_rx_base.sv
// ============================================================================
// Module : rx_base
// Brief  : UART 8N1 byte receiver on an already-synchronized line.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_base
  import rx_operand_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Rx_sync,
  output logic       o_data_avail,
  output logic [7:0] o_data_byte,
  output logic       o_frame_err
);

  localparam int              c_CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [c_CW-1:0] c_LAST      = c_CW'(CLKS_PER_BIT - 1);
  localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t       r_state, w_state_next;
  logic [c_CW-1:0] r_clk_cnt, w_clk_cnt_next;
  logic [2:0]      r_bit_idx, w_bit_idx_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            r_prev, r_avail, r_ferr, w_avail_next, w_ferr_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= RX_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_prev    <= 1'b1;
      r_avail   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_clk_cnt <= w_clk_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_prev    <= Rx_sync;
      r_avail   <= w_avail_next;
      r_ferr    <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clk_cnt_next = r_clk_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_avail_next   = 1'b0;
    w_ferr_next    = 1'b0;
    case (r_state)
      RX_IDLE: begin
        w_clk_cnt_next = '0;
        if (r_prev && !Rx_sync) w_state_next = RX_START;
      end
      RX_START: begin
        // Line back high at mid start bit means a glitch, not a byte.
        if (r_clk_cnt == c_HALF_LAST) begin
          w_clk_cnt_next = '0;
          w_bit_idx_next = '0;
          w_state_next   = Rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == c_LAST) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {Rx_sync, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
          else                   w_bit_idx_next = r_bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == c_LAST) begin
          w_clk_cnt_next = '0;
          w_state_next   = RX_IDLE;
          w_avail_next   = Rx_sync;
          w_ferr_next    = !Rx_sync;
        end
      end
      default: w_state_next = RX_IDLE;
    endcase
  end

  assign o_data_avail = r_avail;
  assign o_data_byte  = r_shift;
  assign o_frame_err  = r_ferr;

endmodule

`default_nettype wire

// File: rtl/rx_operand_loader.sv
// ============================================================================
// Module : rx_operand_loader
// Brief  : Assembles a 64-byte UART frame into two 256-bit operands A and B.
//          Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_operand_loader
  import rx_operand_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 87,
  parameter int TIMEOUT_CYCLES = 16 * CLKS_PER_BIT * 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Rx,
  input  logic                 ack,
  output logic [OPERAND_W-1:0] A,
  output logic [OPERAND_W-1:0] B,
  output logic                 done,
  output logic                 busy,
  output logic                 err
);

  localparam logic [5:0] c_LAST_BYTE = 6'(BYTES_PER_FRAME - 1);

  logic                 r_rx_meta, r_rx_sync;
  logic                 w_byte_valid, w_frame_err, w_timeout;
  logic [7:0]           w_byte;
  ld_state_t            r_state, w_state_next;
  logic [5:0]           r_count;
  logic [OPERAND_W-1:0] r_a, r_b;
  logic                 r_err;
  logic                 w_store, w_drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  rx_base #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock        (clock),
    .reset        (reset),
    .Rx_sync      (r_rx_sync),
    .o_data_avail (w_byte_valid),
    .o_data_byte  (w_byte),
    .o_frame_err  (w_frame_err)
  );

`ifdef RX_TIMEOUT_EN
  localparam int             c_TW  = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [c_TW-1:0] c_TMO = c_TW'(TIMEOUT_CYCLES);
  logic [c_TW-1:0] r_gap;

  // Gap counter restarts on every byte strobe and only runs while collecting.
  always_ff @(posedge clock) begin
    if (reset || r_state != COLLECT || w_byte_valid) r_gap <= '0;
    else if (!w_timeout)                             r_gap <= r_gap + 1'b1;
  end

  assign w_timeout = (r_state == COLLECT) && !w_byte_valid && (r_gap == c_TMO);
`else
  // Timeout disabled: constant 0, parameter kept so both builds share one interface.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  assign w_store = w_byte_valid && (r_state != DONE);
  assign w_drop  = w_byte_valid && (r_state == DONE);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_byte_valid) w_state_next = COLLECT;
      COLLECT: begin
        if (w_byte_valid && r_count == c_LAST_BYTE) w_state_next = DONE;
        else if (w_timeout)                         w_state_next = IDLE;
      end
      DONE:    if (ack) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_frame_err | w_drop | w_timeout;
      if (w_store) begin
        if (r_count[5]) r_b[byte_lsb(r_count[4:0]) +: 8] <= w_byte;
        else            r_a[byte_lsb(r_count[4:0]) +: 8] <= w_byte;
        if (r_count != c_LAST_BYTE) r_count <= r_count + 1'b1;
      end
      // Counter holds at the last index in DONE until the consumer acknowledges.
      if ((r_state == DONE && ack) || w_timeout) r_count <= '0;
    end
  end

  assign A    = r_a;
  assign B    = r_b;
  assign done = (r_state == DONE);
  assign busy = (r_state == COLLECT);
  assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rx_operand_loader.sv
// ============================================================================
// Module : tb_rx_operand_loader
// Brief  : Directed self-checking bench; bit time shortened to keep runs short.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_operand_loader;

  localparam int CPB = 16;
  localparam int TMO = 16 * CPB * 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         Rx    = 1'b1;
  logic         ack   = 1'b0;
  logic [255:0] A, B;
  logic         done, busy, err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, err_cnt = 0, last_strobe = -10, done_rise = -10;
  logic done_q = 1'b0;

  rx_operand_loader #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .Rx    (Rx),
    .ack   (ack),
    .A     (A),
    .B     (B),
    .done  (done),
    .busy  (busy),
    .err   (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    done_q <= done;
    if (err)                 err_cnt     <= err_cnt + 1;
    if (dut.w_byte_valid)    last_strobe <= cyc;
    if (done && !done_q)     done_rise   <= cyc;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clock); Rx = 1'b0; repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin Rx = b[i]; repeat (CPB) @(negedge clock); end
    Rx = stop_bit; repeat (CPB) @(negedge clock);
    Rx = 1'b1;     repeat (CPB) @(negedge clock);
  endtask

  task automatic pulse_ack();
    @(negedge clock); ack = 1'b1;
    @(negedge clock); ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Rx = 1'b1; ack = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_tests++; if (A !== '0)     begin n_fail++; $display("FAIL reset_A got %h exp 0", A); end
    n_tests++; if (B !== '0)     begin n_fail++; $display("FAIL reset_B got %h exp 0", B); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_full_frame();
    logic [255:0] ea, eb;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 32; k++) begin ea[8*k +: 8] = 8'(k); eb[8*k +: 8] = 8'(k + 32); end
    send_byte(8'h00, 1'b1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_mid got %b exp 1", busy); end
    for (int k = 1; k < 64; k++) send_byte(8'(k), 1'b1);
    repeat (2) @(negedge clock);
    n_tests++; if (A[7:0] !== 8'h00)     begin n_fail++; $display("FAIL frame_A_lo got %h exp 00", A[7:0]); end
    n_tests++; if (A[255:248] !== 8'h1F) begin n_fail++; $display("FAIL frame_A_hi got %h exp 1f", A[255:248]); end
    n_tests++; if (B[7:0] !== 8'h20)     begin n_fail++; $display("FAIL frame_B_lo got %h exp 20", B[7:0]); end
    n_tests++; if (B[255:248] !== 8'h3F) begin n_fail++; $display("FAIL frame_B_hi got %h exp 3f", B[255:248]); end
    n_tests++; if (A !== ea) begin n_fail++; $display("FAIL frame_A_all got %h exp %h", A, ea); end
    n_tests++; if (B !== eb) begin n_fail++; $display("FAIL frame_B_all got %h exp %h", B, eb); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL frame_done got %b exp 1", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy got %b exp 0", busy); end
    n_tests++; if (done_rise !== last_strobe + 1) begin n_fail++; $display("FAIL frame_done_latency rise %0d exp %0d", done_rise, last_strobe + 1); end
    n_tests++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL frame_err got %0d exp 0", err_cnt - e0); end
  endtask

  task automatic test_done_drop();
    logic [255:0] a0, b0;
    int e0;
    a0 = A; b0 = B; e0 = err_cnt;
    send_byte(8'h11, 1'b1);
    n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL drop_err got %0d exp 1", err_cnt - e0); end
    n_tests++; if (A !== a0 || B !== b0) begin n_fail++; $display("FAIL drop_AB changed A=%h B=%h", A, B); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL drop_done got %b exp 1", done); end
    pulse_ack();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ack_done got %b exp 0", done); end
    n_tests++; if (A !== a0) begin n_fail++; $display("FAIL ack_A_hold got %h exp %h", A, a0); end
    for (int k = 0; k < 64; k++) send_byte(8'hAA, 1'b1);
    repeat (2) @(negedge clock);
    n_tests++; if (A !== {32{8'hAA}}) begin n_fail++; $display("FAIL aa_A got %h exp all aa", A); end
    n_tests++; if (B !== {32{8'hAA}}) begin n_fail++; $display("FAIL aa_B got %h exp all aa", B); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL aa_done got %b exp 1", done); end
    pulse_ack();
  endtask

  task automatic test_frame_err();
    int e0;
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    e0 = err_cnt;
    send_byte(8'h5A, 1'b0);
    n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_err got %0d exp 1", err_cnt - e0); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy got %b exp 1", busy); end
    pulse_ack();
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL ack_ignored busy=%b done=%b exp 1/0", busy, done); end
    send_byte(8'h44, 1'b1);
    n_tests++; if (A[31:0] !== 32'h44030201) begin n_fail++; $display("FAIL ferr_next got %h exp 44030201", A[31:0]); end
    n_tests++; if (A[63:32] !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL ferr_keep got %h exp aaaaaaaa", A[63:32]); end
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    // Glitch shorter than half a bit time so the mid-start check sees high.
    @(negedge clock); Rx = 1'b0;
    repeat (6) @(negedge clock);
    Rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    n_tests++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err got %0d exp 0", err_cnt - e0); end
    n_tests++; if (A[39:32] !== 8'hAA) begin n_fail++; $display("FAIL glitch_store got %h exp aa", A[39:32]); end
    send_byte(8'h55, 1'b1);
    n_tests++; if (A[39:32] !== 8'h55) begin n_fail++; $display("FAIL glitch_next got %h exp 55", A[39:32]); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) send_byte(8'(8'h60 + k), 1'b1);
    @(negedge clock); Rx = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    reset = 1'b1; Rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_tests++; if (A !== '0 || B !== '0) begin n_fail++; $display("FAIL rstmid_AB A=%h B=%h exp 0", A, B); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    repeat (2 * CPB) @(negedge clock);
    for (int k = 0; k < 64; k++) send_byte(8'hFF, 1'b1);
    repeat (2) @(negedge clock);
    n_tests++; if (A !== {256{1'b1}}) begin n_fail++; $display("FAIL ff_A got %h exp all ones", A); end
    n_tests++; if (B !== {256{1'b1}}) begin n_fail++; $display("FAIL ff_B got %h exp all ones", B); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ff_done got %b exp 1", done); end
    pulse_ack();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL ff_ack got %b exp 0", done); end
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 5; k++) send_byte(8'(8'h10 + k), 1'b1);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_pre got %b exp 1", busy); end
    repeat (TMO + CPB) @(negedge clock);
    n_tests++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL tmo_err got %0d exp 1", err_cnt - e0); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b exp 0", busy); end
    n_tests++; if (A[39:0] !== 40'h1413121110) begin n_fail++; $display("FAIL tmo_keep got %h exp 1413121110", A[39:0]); end
    for (int k = 0; k < 64; k++) send_byte(8'(8'h80 + k), 1'b1);
    repeat (2) @(negedge clock);
    n_tests++; if (A[7:0] !== 8'h80 || A[255:248] !== 8'h9F) begin n_fail++; $display("FAIL tmo_A got %h/%h exp 80/9f", A[7:0], A[255:248]); end
    n_tests++; if (B[7:0] !== 8'hA0 || B[255:248] !== 8'hBF) begin n_fail++; $display("FAIL tmo_B got %h/%h exp a0/bf", B[7:0], B[255:248]); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL tmo_done got %b exp 1", done); end
    pulse_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_done_drop();
    test_frame_err();
    test_glitch();
    test_reset_mid();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rx_operand_loader.md
RX_OPERAND_LOADER -- requirements
Module: rx_operand_loader

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter CLKS_PER_BIT, default 87, meaning clock cycles per UART bit.
REQ-003 Parameter TIMEOUT_CYCLES, default 16*CLKS_PER_BIT*10, meaning the maximum idle gap between bytes inside a frame.
REQ-004 Port clock, input, 1 bit: the single clock.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port Rx, input, 1 bit: asynchronous UART 8N1 serial line, idle high.
REQ-007 Port ack, input, 1 bit: consumer acknowledge; clears done and rearms the block.
REQ-008 Port A, output, 256 bits: first assembled operand.
REQ-009 Port B, output, 256 bits: second assembled operand.
REQ-010 Port done, output, 1 bit: level signal; A and B are complete and stable.
REQ-011 Port busy, output, 1 bit: high while a frame is partially received.
REQ-012 Port err, output, 1 bit: one-cycle pulse on a framing error, overrun or timeout.

Function
REQ-013 Rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Byte reception: a start edge is a synchronized falling edge.
- Start is re-checked at CLKS_PER_BIT/2; if the line is high there, the event is a glitch and reception returns to idle with no byte.
REQ-015 Data bits SHALL be sampled every CLKS_PER_BIT after the start check, 8 bits, LSB first.
- Stop bit sampled high: a one-cycle byte-valid strobe.
- Stop bit sampled low: the byte is discarded and err pulses once.
REQ-016 A frame SHALL be 64 bytes: bytes 0..31 fill A and bytes 32..63 fill B.
- Byte k lands in bits [8*(k mod 32) +: 8], little-endian.
REQ-017 The byte counter SHALL be 6 bits, range 0..63, with no wrap.
- The 64th byte moves the FSM to DONE.
REQ-018 FSM states and transitions:
- IDLE to COLLECT on the first valid byte.
- COLLECT to DONE when the 64th byte is stored.
- DONE to IDLE when ack is high.
REQ-019 A valid byte strobed at cycle t SHALL update A or B at t+1; on the 64th byte, done rises at t+1.
REQ-020 busy SHALL equal 1 in COLLECT and 0 in IDLE and DONE.
REQ-021 A valid byte arriving in DONE SHALL be dropped, pulse err, and leave A and B unchanged.
REQ-022 On ack in DONE: done clears the next cycle and the counter returns to 0.
- A and B hold their values until overwritten.
REQ-023 ack asserted outside DONE SHALL be ignored.
REQ-024 ack coincident with a byte strobe in DONE SHALL drop the byte (pulse err), then clear done.

Reset
REQ-025 Reset SHALL force: A=0, B=0, done=0, busy=0, err=0, counter=0, FSM=IDLE, receiver idle, synchronizer flops=1.
REQ-026 Reset asserted mid-byte or mid-frame SHALL discard all partial data; the next full frame SHALL assemble correctly.

Configuration
REQ-027 Macro RX_TIMEOUT_EN defined:
- In COLLECT, an inter-byte gap exceeding TIMEOUT_CYCLES clock cycles (counted from the last byte strobe) SHALL return the FSM to IDLE.
- The counter SHALL be zeroed and err SHALL pulse once.
- A and B SHALL keep their partial contents.
REQ-028 Macro RX_TIMEOUT_EN undefined: no timeout logic; COLLECT SHALL wait indefinitely.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state encoding (IDLE, COLLECT, DONE);
- the constants BYTES_PER_OPERAND=32 and BYTES_PER_FRAME=64;
- the operand width of 256.
REQ-030 The serial byte receiver SHALL be one sub-module, rx_base, with ports clock, Rx_sync, o_data_avail, o_data_byte, o_frame_err.
- rx_base SHALL mirror the existing transmitter base.

Verification
REQ-031 Send bytes 0x00..0x3F at CLKS_PER_BIT=87. Expect:
- A[7:0]=0x00, A[255:248]=0x1F, B[7:0]=0x20, B[255:248]=0x3F;
- done=1 one cycle after the last strobe;
- busy=0.
REQ-032 Send byte 0x5A with stop bit 0 after 3 good bytes. Expect one err pulse, counter stays 3, and the next good byte lands at A[31:24].
REQ-033 Drive Rx low for 20 cycles, then high. Expect no strobe, counter unchanged and no err.
REQ-034 Send 10 bytes, assert reset 1 cycle, then send a full frame of 0xFF. Expect A and B all-ones and done=1.
REQ-035 With done=1, send byte 0x11. Expect one err pulse and A, B unchanged. Then ack=1 gives done=0 next cycle, and a new frame of 0xAA gives A and B all 0xAA.
REQ-036 With RX_TIMEOUT_EN defined, send 5 bytes, then idle TIMEOUT_CYCLES+1 cycles. Expect one err pulse, busy=0 and counter=0; a following full frame assembles correctly.
